// File: rtl/ram_fifo_pkg.sv
// Shared constants and sizing helpers for the RAM-backed FIFO controller.
package ram_fifo_pkg;
  localparam int OB_DEPTH = 2;
  localparam int OB_CW    = 2;  // holds output-buffer occupancy 0..OB_DEPTH

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Total count reaches DEPTH + OB_DEPTH, so one bit beyond the RAM occupancy width.
  function automatic int count_w(input int aw);
    return aw + 2;
  endfunction
endpackage

// File: rtl/ram_fifo_ctrl_out_buf.sv
// Two-entry in-order output buffer that captures RAM read data and presents the FIFO head.
module fifo_out_buf
  import ram_fifo_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DW-1:0]    load_data,
  input  logic             pop,
  output logic [DW-1:0]    head_data,
  output logic             head_valid,
  output logic [OB_CW-1:0] occ,
  output logic [OB_CW-1:0] occ_nxt
);
  logic [DW-1:0]    ent_q [OB_DEPTH];
  logic [DW-1:0]    ent_d [OB_DEPTH];
  logic [OB_CW-1:0] occ_q, occ_d, slot;

  always_comb begin
    ent_d = ent_q;
    occ_d = occ_q + OB_CW'(load) - OB_CW'(pop);
    slot  = occ_q - OB_CW'(pop);
    // Entry 0 only shifts when a second word stands behind it, so an emptied
    // buffer keeps presenting the last word it held.
    if (pop && occ_q == OB_CW'(2)) ent_d[0] = ent_q[1];
    if (load) begin
      if (slot == '0) ent_d[0] = load_data;
      else            ent_d[1] = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '{default: '0};
      occ_q <= '0;
    end else begin
      ent_q <= ent_d;
      occ_q <= occ_d;
    end
  end

  assign head_data  = ent_q[0];
  assign head_valid = (occ_q != '0);
  assign occ        = occ_q;
  assign occ_nxt    = occ_d;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM (A = write, B = read) with a 2-entry
// registered output stage; first-word-fall-through depth is 2**ADDR_WIDTH + 2.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] count,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic                  ram_we_a,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);
  localparam int              DEPTH  = depth_of(ADDR_WIDTH);
  localparam int              CW     = count_w(ADDR_WIDTH);
  localparam int              MW     = ADDR_WIDTH + 1;
  localparam logic [MW-1:0]   FULL_L = MW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MW-1:0]         mem_used_q, mem_used_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [CW-1:0]         count_q, count_d;
  logic [OB_CW-1:0]      ob_occ, ob_occ_nxt;
  logic [2:0]            ob_demand;
  logic                  push, pop, issue;

  always_comb begin
    in_ready  = !rst && (mem_used_q < FULL_L);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    // Words already in or heading to the buffer once this cycle's pop leaves.
    ob_demand = 3'(ob_occ) + 3'(rd_pending_q) - 3'(pop);
    issue     = (mem_used_q != '0) && (ob_demand < 3'd2);

    wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(issue);
    mem_used_d   = mem_used_q + MW'(push) - MW'(issue);
    rd_pending_d = issue;
    count_d      = CW'(mem_used_d) + CW'(rd_pending_d) + CW'(ob_occ_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_used_q   <= '0;
      rd_pending_q <= 1'b0;
      count_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_used_q   <= mem_used_d;
      rd_pending_q <= rd_pending_d;
      count_q      <= count_d;
    end
  end

  // ram_q_b carries the issued word exactly in the cycle after the issue.
  fifo_out_buf #(.DW(DATA_WIDTH)) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (rd_pending_q),
    .load_data  (ram_q_b),
    .pop        (pop),
    .head_data  (out_data),
    .head_valid (out_valid),
    .occ        (ob_occ),
    .occ_nxt    (ob_occ_nxt)
  );

  assign count      = count_q;
  assign ram_data_a = in_data;
  assign ram_addr_a = wr_ptr_q;
  assign ram_we_a   = push;
  assign ram_data_b = '0;
  assign ram_addr_b = rd_ptr_q;
  assign ram_we_b   = 1'b0;
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream of the dual-port block RAM (`ram`) and consumes its read data.
- Drives RAM port A as the write port and port B as the read port.
- Registers `ram_q_b` into a 2-entry output buffer.
- Presents valid/ready streams on both sides.
- Together with `ram`, forms a first-word-fall-through FIFO of depth 2**ADDR_WIDTH + 2.

Parameters:
DATA_WIDTH, 8, word width; must match the `ram` instance.
ADDR_WIDTH, 10, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  write data.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  controller accepts this cycle.
- out_data  out  DATA_WIDTH  head-of-FIFO word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes out_data.
- count  out  ADDR_WIDTH+2  total words held.
- ram_data_a  out  DATA_WIDTH  equals in_data.
- ram_addr_a  out  ADDR_WIDTH  write pointer.
- ram_we_a  out  1  push strobe.
- ram_data_b  out  DATA_WIDTH  tied 0.
- ram_addr_b  out  ADDR_WIDTH  read pointer.
- ram_we_b  out  1  tied 0.
- ram_q_b  in  DATA_WIDTH  RAM port-B registered read data.

Interface: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
Events
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = !rst & (mem_used < DEPTH).
  - mem_used is registered, so in_ready has no combinational path from in_valid.
- ram_we_a = push, combinational; ram_addr_a = wr_ptr.

Read issue
- issue = (mem_used > 0) & (ob_count + rd_pending - pop < 2).
- ram_addr_b = rd_ptr at all times; port B reads every cycle, and only issue cycles are tracked.
- On issue: rd_ptr increments and rd_pending <= 1 next cycle; otherwise rd_pending <= 0.

Data path and counters
- When rd_pending = 1, ram_q_b holds the issued word; it is written into the output buffer at that clock edge.
- mem_used += push, -= issue; push and issue together leave it unchanged.
- Pointers wrap modulo DEPTH naturally; no extra wrap logic.

Output buffer
- 2 entries, in-order; out_data = head entry; out_valid = (ob_count > 0).
- Simultaneous load and pop in the same cycle is legal.

Count
- count = mem_used + rd_pending + ob_count, registered; max DEPTH+2.

Latency
- Push in cycle n → mem_used = 1 in n+1 → issue in n+1 → buffer load at end of n+2 → out_valid in n+3.
- Empty-to-output latency is 3 cycles.
- Sustained throughput is 1 word/cycle with in_valid=out_ready=1.

RAM hazards
- A read never targets an address written in the same cycle: a word is readable only from the cycle after its push.
- A RAM slot is freed at issue; mem_used is registered, so a push can reuse that slot at earliest the following cycle. No same-address mixed-port collision occurs.

Boundaries
- Full (mem_used = DEPTH): in_ready = 0; push ignored while in_valid is held.
- Empty: out_valid = 0 and out_data holds its last value. A pop attempt with out_valid = 0 is a no-op.
- Push to a full RAM coinciding with an issue: not accepted, because in_ready uses the pre-issue mem_used.

Reset (any cycle, including mid-transfer)
- wr_ptr, rd_ptr, mem_used, rd_pending, ob_count <= 0.
- Buffer entries <= 0, so out_data = 0, out_valid = 0, count = 0.
- in_ready = 0 during reset.
- RAM contents are not cleared; stale words are unreachable.

Decomposition:
Package ram_fifo_pkg holds:
- DEPTH derivation from ADDR_WIDTH.
- Count width (ADDR_WIDTH+2).
- Output-buffer depth constant OB_DEPTH = 2.

One sub-module is natural: fifo_out_buf.
- 2-entry in-order buffer.
- Ports: load, load_data, pop, head data/valid, occupancy.
- The top level keeps pointers, mem_used, issue logic and RAM port wiring.

Test Plan:
1. Reset then a single push of 0xA5 in cycle 0, out_ready=1:
   - ram_we_a=1 with addr 0 in cycle 0; ram_addr_b=0 issued in cycle 1.
   - out_valid=1 with out_data=0xA5 in cycle 3; count returns to 0 the cycle after the pop.
2. Streaming 0x00..0xFF with in_valid=out_ready=1 continuously:
   - Output appears in order from cycle 3, one word per cycle, no bubbles.
   - count stays ≤ 3.
3. Fill with out_ready=0, ADDR_WIDTH=4:
   - Accepts exactly 18 words (16 RAM + 2 buffer); count=18 and in_ready=0.
   - in_ready does not drop until mem_used=16.
   - Raise out_ready: 18 words drain in push order, count=0 at the end, out_valid=0.
4. Pointer wrap, ADDR_WIDTH=4:
   - Push/pop 40 words with random in_valid/out_ready stalls.
   - Data order is preserved across two pointer wraps; no duplicates, no drops.
5. Full-boundary race, ADDR_WIDTH=4:
   - At mem_used=16 with out_ready asserted and in_valid held high, in_ready stays 0 in the issue cycle and rises the following cycle.
   - The next word is written to the just-freed address.
6. Reset mid-stream with 10 words held:
   - One cycle of rst=1 → out_valid=0, out_data=0, count=0, in_ready=0 during reset.
   - A subsequent push of 0x3C emerges as the first output, 3 cycles later.
